// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access unit: op codes, bus widths,
// the fetch bubble instruction, UART register addresses and FSM encodings.
package mem_access_pkg;

    localparam int DATA_W     = 16;
    localparam int RAM_ADDR_W = 18;

    localparam logic [1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [1:0] MEM_OP_READ  = 2'd1;
    localparam logic [1:0] MEM_OP_WRITE = 2'd2;

    localparam logic [DATA_W-1:0] INST_NOP = 16'h0800;

    // Everything below this address is SRAM; the BFxx page is I/O space.
    localparam logic [DATA_W-1:0] SRAM_LIMIT          = 16'hBF00;
    localparam logic [DATA_W-1:0] UART_DATA_ADDR_DEF  = 16'hBF00;
    localparam logic [DATA_W-1:0] UART_STAT_ADDR_DEF  = 16'hBF01;

    // One-hot state bits, so strobes can be taken straight off a flop.
    localparam int MEMST_IDLE_BIT     = 0;
    localparam int MEMST_RD_BIT       = 1;
    localparam int MEMST_WR_SETUP_BIT = 2;
    localparam int MEMST_WR_PULSE_BIT = 3;
    localparam int MEMST_WR_HOLD_BIT  = 4;
    localparam int MEMST_DONE_BIT     = 5;

    typedef enum logic [5:0] {
        MEMST_IDLE     = 6'b000001,
        MEMST_RD       = 6'b000010,
        MEMST_WR_SETUP = 6'b000100,
        MEMST_WR_PULSE = 6'b001000,
        MEMST_WR_HOLD  = 6'b010000,
        MEMST_DONE     = 6'b100000
    } memst_e;

    typedef enum logic [1:0] {
        REGION_SRAM,
        REGION_UART_DATA,
        REGION_UART_STAT,
        REGION_UNMAPPED
    } region_e;

    function automatic logic [RAM_ADDR_W-1:0] to_ram_addr(input logic [DATA_W-1:0] a);
        return {2'b00, a};
    endfunction

endpackage

// File: rtl/mem_access_mmio_decode.sv
// Classifies a data address as SRAM, UART data, UART status or unmapped I/O.
module mmio_decode
    import mem_access_pkg::*;
#(
    parameter logic [DATA_W-1:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [DATA_W-1:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
)(
    input  logic [DATA_W-1:0] addr_i,
    output region_e           region_o
);

    // UART registers take priority so a relocated UART can never alias SRAM.
    always_comb begin
        region_o = REGION_UNMAPPED;
        if (addr_i == UART_DATA_ADDR) begin
            region_o = REGION_UART_DATA;
        end else if (addr_i == UART_STAT_ADDR) begin
            region_o = REGION_UART_STAT;
        end else if (addr_i < SRAM_LIMIT) begin
            region_o = REGION_SRAM;
        end
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access unit: arbitrates the shared asynchronous SRAM between
// instruction fetch and load/store, sequences the write strobe, and serves
// the memory-mapped UART. Stalls the pipeline while an access is in flight.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int                WR_CYCLES      = 2,
    parameter logic [DATA_W-1:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [DATA_W-1:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mem_op,
    input  logic [DATA_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_inst,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_req,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_dout,
    input  logic [DATA_W-1:0]     ram_din,
    output logic                  ram_dq_oe,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_tx_valid,
    input  logic                  uart_tx_ready,
    input  logic [7:0]            uart_rx_data,
    input  logic                  uart_rx_valid,
    output logic                  uart_rx_ack
);

    localparam int CntW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    memst_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    region_e region;
    logic    is_read;
    logic    is_write;

    mmio_decode #(
        .UART_DATA_ADDR (UART_DATA_ADDR),
        .UART_STAT_ADDR (UART_STAT_ADDR)
    ) u_decode (
        .addr_i   (mem_addr),
        .region_o (region)
    );

    assign is_read  = (mem_op == MEM_OP_READ);
    assign is_write = (mem_op == MEM_OP_WRITE);

    // Strobes come straight off state flops so they cannot glitch, and the
    // async reset releases we_n without needing a clock edge.
    assign ram_we_n     = ~state_q[MEMST_WR_PULSE_BIT];
    assign ram_dq_oe    = state_q[MEMST_WR_SETUP_BIT] | state_q[MEMST_WR_PULSE_BIT]
                        | state_q[MEMST_WR_HOLD_BIT];
    assign ram_dout     = wdata_q;
    assign uart_tx_data = mem_wdata[7:0];

    // State, pulse counter, captured load data and latched store address/data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEMST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and SRAM/UART/pipeline outputs; fetch owns the SRAM by default.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        ram_addr      = to_ram_addr(if_addr);
        ram_ce_n      = 1'b0;
        ram_oe_n      = 1'b0;
        if_inst       = ram_din;
        mem_rdata     = '0;
        stall_req     = 1'b0;
        uart_tx_valid = 1'b0;
        uart_rx_ack   = 1'b0;

        unique case (state_q)
            MEMST_IDLE: begin
                if (is_read && region == REGION_SRAM) begin
                    ram_addr  = to_ram_addr(mem_addr);
                    if_inst   = INST_NOP;
                    stall_req = 1'b1;
                    rd_d      = ram_din;
                    state_d   = MEMST_RD;
                end else if (is_write && region == REGION_SRAM) begin
                    ram_addr  = to_ram_addr(mem_addr);
                    ram_oe_n  = 1'b1;
                    if_inst   = INST_NOP;
                    stall_req = 1'b1;
                    waddr_d   = mem_addr;
                    wdata_d   = mem_wdata;
                    state_d   = MEMST_WR_SETUP;
                end else if (is_read) begin
                    if (region == REGION_UART_DATA) begin
                        mem_rdata   = {8'h00, uart_rx_data};
                        uart_rx_ack = uart_rx_valid;
                    end else if (region == REGION_UART_STAT) begin
                        mem_rdata = {14'b0, uart_rx_valid, uart_tx_ready};
                    end
                end else if (is_write && region == REGION_UART_DATA) begin
                    if (uart_tx_ready) begin
                        uart_tx_valid = 1'b1;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
            end
            MEMST_RD: begin
                mem_rdata = rd_q;
                state_d   = MEMST_IDLE;
            end
            MEMST_WR_SETUP: begin
                ram_addr  = to_ram_addr(waddr_q);
                ram_oe_n  = 1'b1;
                if_inst   = INST_NOP;
                stall_req = 1'b1;
                cnt_d     = CntW'(WR_CYCLES - 1);
                state_d   = MEMST_WR_PULSE;
            end
            MEMST_WR_PULSE: begin
                ram_addr  = to_ram_addr(waddr_q);
                ram_oe_n  = 1'b1;
                if_inst   = INST_NOP;
                stall_req = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MEMST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            MEMST_WR_HOLD: begin
                ram_addr  = to_ram_addr(waddr_q);
                ram_oe_n  = 1'b1;
                if_inst   = INST_NOP;
                stall_req = 1'b1;
                state_d   = MEMST_DONE;
            end
            MEMST_DONE: begin
                state_d = MEMST_IDLE;
            end
            default: begin
                state_d = MEMST_IDLE;
            end
        endcase

        // While reset is held the SRAM is deselected and the pipeline sees a bubble.
        if (!rst) begin
            ram_ce_n      = 1'b1;
            ram_oe_n      = 1'b1;
            if_inst       = INST_NOP;
            stall_req     = 1'b0;
            uart_tx_valid = 1'b0;
            uart_rx_ack   = 1'b0;
        end
    end

endmodule
